flash_pattern_gen: RTL
======================

Name: flash_pattern_gen

Overview:
- Downstream consumer of the video timing generator; turns visible pixel counters and sync/DE into the lag-test image.
- Alternates black "dark" frames with frames carrying a centred white box, frame-locked.
- Emits a one-cycle marker on the first active pixel of every flash frame, so the latency measurement logic has an exact time zero.
- Pipelines sync and DE alongside RGB so all outputs stay aligned.

Parameters:
- BOX_W, 12'd64, flash box width in pixels.
- BOX_H, 12'd64, flash box height in lines.
- BOX_RGB, 24'hFFFFFF, box colour.

Ports:
- clock  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run pattern; sampled only at frame boundary.
- dark_frames  in  8  frames per dark phase (0 treated as 1).
- flash_frames  in  8  frames per flash phase (0 treated as 1).
- h_active  in  12  active width of current mode.
- v_active  in  12  active height of current mode.
- vsync_pol  in  1  active level of vsync_in.
- visible_x  in  12  visible column from timing generator.
- visible_y  in  12  visible row from timing generator.
- hsync_in  in  1  hsync from timing generator.
- vsync_in  in  1  vsync from timing generator.
- de_in  in  1  data enable from timing generator.
- rgb  out  24  pixel colour {R,G,B}.
- hsync_out  out  1  hsync delayed 2 cycles.
- vsync_out  out  1  vsync delayed 2 cycles.
- de_out  out  1  DE delayed 2 cycles.
- flash_start  out  1  one-cycle pulse on first de_out of a flash frame.
- phase  out  2  current state (0 IDLE, 1 DARK, 2 FLASH).

Behaviour:
- Reset (async, reset_n=0):
  - rgb=0, de_out=0, flash_start=0, hsync_out=vsync_out=0.
  - State IDLE, frame counter 0, vsync history register 0, first-pixel flag cleared.
- Latency: all outputs (rgb, hsync_out, vsync_out, de_out, flash_start) lag their inputs by exactly 2 clocks, and are mutually aligned.
  - Stage 1: register inputs and box-compare results.
  - Stage 2: colour select.
- frame_tick: one cycle when vsync_in==vsync_pol and the previous-cycle vsync_in!=vsync_pol (start of vsync pulse).
- Box region (unsigned 12-bit arithmetic):
  - x0=(h_active-BOX_W)>>1, y0=(v_active-BOX_H)>>1.
  - in_box = x0<=visible_x<x0+BOX_W and y0<=visible_y<y0+BOX_H.
  - If BOX_W>h_active or BOX_H>v_active, in_box=0 (no wrap artefacts).
- State machine (transitions only on frame_tick):
  - IDLE: enable=1 -> DARK, cnt=0.
  - DARK: enable=0 -> IDLE. Else if cnt>=max(dark_frames,1)-1 -> FLASH, cnt=0. Else cnt+1.
  - FLASH: enable=0 -> IDLE. Else if cnt>=max(flash_frames,1)-1 -> DARK, cnt=0. Else cnt+1.
- Colour (stage 2):
  - de=0 -> 0.
  - FLASH and in_box -> BOX_RGB.
  - Otherwise -> 0.
- flash_start:
  - A flag sets on frame_tick when the next state is FLASH (entering or staying).
  - On the first stage-2 cycle with de=1 and the flag set: flash_start=1 and the flag clears.
  - The pulse occurs once per flash frame, even if the box is not visible.
- Changing dark_frames/flash_frames mid-phase takes effect at the next frame_tick compare.
- Deasserting enable mid-frame has no effect until the next frame_tick; no torn frames.
- Reset mid-frame: outputs go to reset values immediately. After release, sync passthrough resumes after 2 clocks. Pattern restarts from IDLE.
- frame_tick coincident with the stage-2 flag-clear cycle: the set wins (new frame).

Optional Feature:
- Macro FLASH_PATTERN_BORDER_EN.
- Defined: in DARK and FLASH, active pixels with visible_x==0, visible_x==h_active-1, visible_y==0 or visible_y==v_active-1 output 24'h404040 unless in_box (box has priority). This gives a visible frame edge for display alignment checks.
- Undefined: no border logic; those pixels follow the normal colour rule (black in DARK).
- Latency is unchanged either way.

Test Plan:
- Reset then release with h_active=16, v_active=8, BOX_W=4, BOX_H=2, enable=0 -> rgb=0 for all pixels, hsync_out/vsync_out/de_out equal inputs delayed exactly 2 clocks, phase=0.
- enable=1, dark_frames=2, flash_frames=1 -> phase sequence per frame_tick: DARK, DARK, FLASH, DARK, DARK, FLASH…; FLASH frames show FFFFFF only at x=6..9, y=3..4; flash_start fires once per FLASH frame, coincident with the first de_out pixel (x=0, y=0).
- dark_frames=0, flash_frames=0 -> treated as 1: DARK and FLASH alternate every frame.
- Deassert enable mid FLASH frame -> the current frame completes with the box; IDLE after the next frame_tick; no further flash_start.
- BOX_W=20 (>h_active=16) in FLASH -> rgb stays 0; flash_start still pulses.
- With FLASH_PATTERN_BORDER_EN, DARK frame -> pixels x=0/15 or y=0/7 give 404040; interior 0; in FLASH the box pixels stay FFFFFF.

Source files
------------

// File: rtl/flash_pattern_gen.sv
// flash_pattern_gen
//   Lag-test pattern generator that sits behind the video timing generator.
//   Alternates black DARK frames with FLASH frames that carry a centred box.
//   Emits a one-cycle flash_start marker on the first active pixel of every
//   FLASH frame. Sync and DE are carried through the same two-stage pipeline
//   as the colour, so every output lags its input by exactly two clocks.
//
//   Optional build macro FLASH_PATTERN_BORDER_EN: when defined, the outermost
//   active pixels of DARK and FLASH frames are drawn in grey (24'h404040).
//   The box keeps priority over the border.
//
// Ports
//   clock, reset_n            pixel clock, asynchronous active-low reset
//   enable                    run pattern (sampled on frame_tick only)
//   dark_frames, flash_frames phase lengths in frames (0 behaves as 1)
//   h_active, v_active        active size of the current mode
//   vsync_pol                 active level of vsync_in
//   visible_x, visible_y      pixel position from the timing generator
//   hsync_in, vsync_in, de_in sync and data enable from the timing generator
//   rgb                       pixel colour {R,G,B}
//   hsync_out, vsync_out      syncs delayed by two clocks
//   de_out                    data enable delayed by two clocks
//   flash_start               first de_out pixel of a FLASH frame
//   phase                     0 IDLE, 1 DARK, 2 FLASH
module flash_pattern_gen #(
  parameter logic [11:0] BOX_W   = 12'd64,
  parameter logic [11:0] BOX_H   = 12'd64,
  parameter logic [23:0] BOX_RGB = 24'hFFFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  dark_frames,
  input  logic [7:0]  flash_frames,
  input  logic [11:0] h_active,
  input  logic [11:0] v_active,
  input  logic        vsync_pol,
  input  logic [11:0] visible_x,
  input  logic [11:0] visible_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [23:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic        flash_start,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DARK  = 2'd1,
    ST_FLASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vs_prev_q, vs_prev_d;
  logic        flag_q, flag_d;

  logic        hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d, in_box1_q, in_box1_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d, fs_q, fs_d;

  logic        frame_tick_s;
  logic [7:0]  dark_last_s, flash_last_s;
  logic [11:0] x0_s, y0_s, x1_s, y1_s;
  logic        box_fits_s, in_box_s;

`ifdef FLASH_PATTERN_BORDER_EN
  logic        border_s;
  logic        border1_q, border1_d;
`endif

  // Frame tick and box geometry, all combinational on the current inputs.
  always_comb begin
    frame_tick_s = (vsync_in == vsync_pol) && (vs_prev_q != vsync_pol);
    // Index of the last frame in each phase; a length of 0 counts as 1.
    dark_last_s  = (dark_frames  == 8'd0) ? 8'd0 : (dark_frames  - 8'd1);
    flash_last_s = (flash_frames == 8'd0) ? 8'd0 : (flash_frames - 8'd1);
    x0_s = (h_active - BOX_W) >> 1;
    y0_s = (v_active - BOX_H) >> 1;
    x1_s = x0_s + BOX_W;
    y1_s = y0_s + BOX_H;
    // An oversized box would wrap the subtraction above, so suppress it.
    box_fits_s = (BOX_W <= h_active) && (BOX_H <= v_active);
    in_box_s   = box_fits_s &&
                 (visible_x >= x0_s) && (visible_x < x1_s) &&
                 (visible_y >= y0_s) && (visible_y < y1_s);
`ifdef FLASH_PATTERN_BORDER_EN
    border_s = (visible_x == 12'd0) || (visible_x == (h_active - 12'd1)) ||
               (visible_y == 12'd0) || (visible_y == (v_active - 12'd1));
`endif
  end

  // Phase state machine; it only moves on frame_tick so frames never tear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_DARK;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DARK: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (cnt_q >= dark_last_s) begin
            state_d = ST_FLASH;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_FLASH: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (cnt_q >= flash_last_s) begin
            state_d = ST_DARK;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // First-pixel flag: armed for each FLASH frame, consumed by the first
  // stage-2 pixel with DE. Arming wins when both happen in one cycle.
  always_comb begin
    vs_prev_d = vsync_in;
    fs_d      = de1_q && flag_q;
    if (frame_tick_s && (state_d == ST_FLASH)) begin
      flag_d = 1'b1;
    end else if (de1_q && flag_q) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Stage 1 captures sync/DE and the position compares; stage 2 picks colour.
  always_comb begin
    hs1_d     = hsync_in;
    vs1_d     = vsync_in;
    de1_d     = de_in;
    in_box1_d = in_box_s;
`ifdef FLASH_PATTERN_BORDER_EN
    border1_d = border_s;
`endif
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
    rgb_d = 24'h000000;
    if (!de1_q) begin
      rgb_d = 24'h000000;
    end else if ((state_q == ST_FLASH) && in_box1_q) begin
      rgb_d = BOX_RGB;
`ifdef FLASH_PATTERN_BORDER_EN
    end else if ((state_q != ST_IDLE) && border1_q) begin
      rgb_d = 24'h404040;
`endif
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // All state and pipeline registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      vs_prev_q <= 1'b0;
      flag_q    <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      de1_q     <= 1'b0;
      in_box1_q <= 1'b0;
`ifdef FLASH_PATTERN_BORDER_EN
      border1_q <= 1'b0;
`endif
      rgb_q     <= 24'h000000;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      de2_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= vs_prev_d;
      flag_q    <= flag_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      de1_q     <= de1_d;
      in_box1_q <= in_box1_d;
`ifdef FLASH_PATTERN_BORDER_EN
      border1_q <= border1_d;
`endif
      rgb_q     <= rgb_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      de2_q     <= de2_d;
      fs_q      <= fs_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign de_out      = de2_q;
  assign flash_start = fs_q;
  assign phase       = state_q;

endmodule
